// File: rtl/rv_ctrl_pkg.sv
// Shared constants and types for the multicycle RISC-V control unit.
// Opcodes, FSM state encoding and ALU operation codes.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8
  } state_e;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  // AOP_NONE parks the ALU at operation 0000 in states that don't use it
  typedef enum logic [1:0] {
    AOP_ADD   = 2'b00,
    AOP_SUB   = 2'b01,
    AOP_FUNCT = 2'b10,
    AOP_NONE  = 2'b11
  } alu_op_e;

endpackage

// File: rtl/multicycle_control_alu.sv
// ALU-control decode: maps alu_op and funct to the 4-bit ALU operation.
// Flags funct patterns outside add/sub/and/or.
module alu_control
  import rv_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [3:0] funct,
  output logic [3:0] operation,
  output logic       bad_funct
);

  always_comb begin
    operation = ALU_AND;
    bad_funct = 1'b0;
    case (alu_op)
      AOP_ADD: operation = ALU_ADD;
      AOP_SUB: operation = ALU_SUB;
      AOP_FUNCT: begin
        case (funct)
          4'b0000: operation = ALU_ADD;
          4'b1000: operation = ALU_SUB;
          4'b0111: operation = ALU_AND;
          4'b0110: operation = ALU_OR;
          default: begin
            operation = ALU_ADD;
            bad_funct = 1'b1;
          end
        endcase
      end
      default: operation = ALU_AND;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control FSM: fetch/decode/execute/memory/writeback sequencing
// with a req/ready memory handshake and a wait-cycle timeout.
module multicycle_control
  import rv_ctrl_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opCode,
  input  logic [3:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       operation,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             illegal,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state
);

  localparam int WAIT_W =
    (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               illegal_q, illegal_d;
  logic [WAIT_W-1:0]  waitcnt_q, waitcnt_d;
  logic [1:0]         alu_op;
  logic               bad_funct;
  logic               retire;
  logic               mem_state;
  logic               timeout;

  alu_control u_alu_control (
    .alu_op    (alu_op),
    .funct     (funct),
    .operation (operation),
    .bad_funct (bad_funct)
  );

  assign mem_state = (state_q == S_FETCH) ||
                     (state_q == S_MEMRD) ||
                     (state_q == S_MEMWR);

  // Fires on the MEM_TIMEOUT-th consecutive cycle without mem_ready
  assign timeout = (MEM_TIMEOUT != 0) && mem_state && !mem_ready &&
                   (int'(waitcnt_q) == MEM_TIMEOUT - 1);

  always_comb begin
    state_d    = state_q;
    illegal_d  = 1'b0;
    retire     = 1'b0;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_op     = AOP_NONE;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = AOP_ADD;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b10;
        alu_op    = AOP_ADD;
        case (opCode)
          OP_RTYPE:          state_d = S_EXEC;
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_BRANCH:         state_d = S_BRANCH;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = AOP_ADD;
        state_d   = (opCode == OP_LOAD) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = AOP_FUNCT;
        illegal_d = bad_funct;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = AOP_SUB;
        pc_src    = 1'b1;
        pc_write  = zero;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    if (timeout) begin
      state_d   = S_FETCH;
      illegal_d = 1'b1;
    end
    if (mem_state && !mem_ready && !timeout)
      waitcnt_d = waitcnt_q + WAIT_W'(1);
    else
      waitcnt_d = '0;
    retired_d = retired_q + CNT_W'(retire);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
      illegal_q <= 1'b0;
      waitcnt_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
      waitcnt_q <= waitcnt_d;
    end
  end

  assign illegal = illegal_q;
  assign retired = retired_q;
  assign state   = state_q;

endmodule
